ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage pipeline, between the decode stage and the memory stage (MEM).
//  - Latches one instruction per valid/allow_in handshake.
//  - Runs 32-bit signed/unsigned divide and modulo on an iterative restoring divider.
//  - Checks load/store alignment and issues the data-SRAM request.
//  - Forwards its result back to decode for bypass and load-use stalls.
// PARAMETERS
//  CTRL_W    85  width of the passthrough control bundle ctrl_in/mem_ctrl
//  DIV_ITER  32  restoring-divider iterations (one quotient bit per cycle)
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high
//  flush           in   1       CSR exception/ertn flush; kills the EX instruction
//  later_ex        in   1       MEM or WB holds an exception/ertn; suppresses the SRAM request
//  ID_to_EX_valid  in   1       decode offers an instruction
//  EX_allow_in     out  1       EX can accept this cycle
//  MEM_allow_in    in   1       MEM can accept this cycle
//  EX_to_MEM_valid out  1       EX offers an instruction to MEM
//  id_pc           in   32      instruction PC
//  src1            in   32      divider dividend
//  src2            in   32      divider divisor
//  alu_result      in   32      ALU result from decode-side ALU; also the load/store address
//  st_data         in   32      store data (rd value)
//  div_op          in   4       one-hot {mod_wu,div_wu,mod_w,div_w}; 0 = not a divide
//  mem_rd          in   1       load
//  mem_wr          in   1       store
//  mem_size        in   3       one-hot {4B,2B,1B}
//  mem_signed      in   1       load sign-extend flag
//  ctrl_in         in   CTRL_W  {dest[4:0],gr_we,ex_SYS,ex_BRK,ex_ADEF,ex_INE,is_ertn,op_csr,csr_num,csr_wmask,rj}
//  mem_pc          out  32      registered PC to MEM
//  mem_result      out  32      divider result when div_op!=0, else alu_result
//  mem_ld_size     out  3       mem_size if mem_rd, else 0
//  mem_ld_signed   out  1       registered mem_signed
//  mem_ex_ADEM     out  1       misaligned load/store
//  mem_ctrl        out  CTRL_W  registered ctrl_in
//  data_sram_en    out  1       SRAM request
//  data_sram_we    out  4       byte write enables
//  data_sram_addr  out  32      {alu_result[31:2],2'b00}
//  data_sram_wdata out  32      st_data replicated per size
//  fwd_dest        out  5       dest when EX_valid & gr_we, else 0
//  fwd_result      out  32      = mem_result
//  fwd_is_load     out  1       EX_valid & mem_rd (load-use stall); also high while the divider is busy
// BEHAVIOUR
//  Handshake
//  - EX_allow_in = ~EX_valid | (EX_ready_go & MEM_allow_in); EX_to_MEM_valid = EX_valid & EX_ready_go.
//  - Stage registers load on ID_to_EX_valid & EX_allow_in.
//  - reset|flush: EX_valid<=0 and divider state<=IDLE. flush wins over a simultaneous accept.
//  Reset values
//  - All outputs qualified by EX_valid read 0 after reset: EX_to_MEM_valid, data_sram_en/we, fwd_dest, fwd_is_load.
//  Divider FSM: IDLE -> BUSY -> DONE -> IDLE
//  - IDLE -> BUSY: EX_valid & div_op!=0 & no ex flag in ctrl. Loads |src1|, |src2| (abs only for signed ops),
//    sign_q = s1^s2, sign_r = s1; counter <= 0.
//  - BUSY: one restoring step per cycle. After DIV_ITER steps go to DONE and apply signs to q and r.
//  - DONE: EX_ready_go=1; on MEM handshake go to IDLE.
//  - Latency: 1 cycle for a non-divide; 34 cycles from EX entry to EX_to_MEM_valid for a divide.
//  - Divide by zero: q=0xFFFFFFFF, r=dividend (sign rules still apply).
//  - INT_MIN/-1: q=0x80000000, r=0. Neither case raises an exception.
//  - A divide carrying an incoming exception bypasses the FSM: ready_go=1, result=alu_result.
//  Memory request
//  - mem_ex_ADEM = (2B & addr[0]) | (4B & addr[1:0]!=0), for mem_rd|mem_wr.
//  - data_sram_en = EX_valid & (mem_rd|mem_wr) & ~ADEM & ~incoming ex & ~later_ex & ~flush & MEM_allow_in.
//  - we = mem_wr ? (1B: 4'b0001<<addr[1:0] | 2B: 4'b0011<<addr[1:0] | 4B: 4'hF) : 0.
//  - wdata = 1B {4{st_data[7:0]}} | 2B {2{st_data[15:0]}} | 4B st_data.
//  - Request issues only in the handshake cycle, exactly once per instruction.
// TESTING
//  - div.w src1=-7, src2=2 -> after 34 cycles mem_result=0xFFFFFFFD; mod.w same operands -> 0xFFFFFFFF.
//  - div.wu 0x0000000A by 0 -> 0xFFFFFFFF; mod.wu -> 0x0000000A; no exception flag.
//  - st.b addr=0x1003, st_data=0x000000AB -> en=1, we=4'b1000, wdata=0xABABABAB, addr=0x1000.
//  - ld.w addr=0x1002 -> mem_ex_ADEM=1, data_sram_en=0, EX_to_MEM_valid=1 next to MEM.
//  - flush asserted at divider cycle 10 -> EX_valid=0 and FSM IDLE next cycle;
//    next div completes with correct result.
//  - MEM_allow_in=0 for 5 cycles with a store in EX -> no SRAM request until release,
//    then exactly one request; later_ex=1 -> none.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: latches one instruction per handshake, runs an iterative restoring
// divider for div/mod ops, checks load/store alignment and issues the data-SRAM request.
module ex_stage #(
  parameter int CTRL_W   = 85,
  parameter int DIV_ITER = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              later_ex,
  input  logic              ID_to_EX_valid,
  output logic              EX_allow_in,
  input  logic              MEM_allow_in,
  output logic              EX_to_MEM_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       src1,
  input  logic [31:0]       src2,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       st_data,
  input  logic [3:0]        div_op,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       mem_pc,
  output logic [31:0]       mem_result,
  output logic [2:0]        mem_ld_size,
  output logic              mem_ld_signed,
  output logic              mem_ex_ADEM,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_we,
  output logic [31:0]       data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  output logic [4:0]        fwd_dest,
  output logic [31:0]       fwd_result,
  output logic              fwd_is_load
);

  localparam int CNT_W = $clog2(DIV_ITER + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  logic              ex_valid_q;
  logic [31:0]       pc_q;
  logic [31:0]       src1_q;
  logic [31:0]       src2_q;
  logic [31:0]       alu_q;
  logic [31:0]       st_data_q;
  logic [3:0]        div_op_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [2:0]        mem_size_q;
  logic              mem_signed_q;
  logic [CTRL_W-1:0] ctrl_q;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       dsor_q, dsor_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic [31:0]       res_q, res_d;

  logic              ex_in;
  logic              is_div;
  logic              div_signed;
  logic              div_is_mod;
  logic              div_start;
  logic              div_done;
  logic              div_pending;
  logic              ex_ready_go;
  logic              accept;

  logic [32:0]       step_rem;
  logic              step_ge;
  logic [31:0]       step_sub;
  logic [31:0]       q_next;
  logic [31:0]       r_next;
  logic [31:0]       abs1;
  logic [31:0]       abs2;

  logic              is_mem;
  logic [1:0]        addr_lo;

  // Control bundle layout from the top: dest[4:0], gr_we, then the four exception flags.
  assign ex_in      = |ctrl_q[CTRL_W-7 -: 4];
  assign is_div     = |div_op_q;
  assign div_signed = div_op_q[0] | div_op_q[1];
  assign div_is_mod = div_op_q[1] | div_op_q[3];
  assign div_start  = ex_valid_q & is_div & ~ex_in;

  assign EX_allow_in     = ~ex_valid_q | (ex_ready_go & MEM_allow_in);
  assign EX_to_MEM_valid = ex_valid_q & ex_ready_go;
  assign accept          = ID_to_EX_valid & EX_allow_in;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid_q <= 1'b0;
    end else if (EX_allow_in) begin
      ex_valid_q <= ID_to_EX_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q         <= id_pc;
      src1_q       <= src1;
      src2_q       <= src2;
      alu_q        <= alu_result;
      st_data_q    <= st_data;
      div_op_q     <= div_op;
      mem_rd_q     <= mem_rd;
      mem_wr_q     <= mem_wr;
      mem_size_q   <= mem_size;
      mem_signed_q <= mem_signed;
      ctrl_q       <= ctrl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q   <= cnt_d;
    quo_q   <= quo_d;
    rem_q   <= rem_d;
    dsor_q  <= dsor_d;
    qsign_q <= qsign_d;
    rsign_q <= rsign_d;
    res_q   <= res_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (div_start) state_d = DIV_BUSY;
      DIV_BUSY: if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      DIV_DONE: if (EX_to_MEM_valid && MEM_allow_in) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    div_done    = (state_q == DIV_DONE);
    div_pending = is_div & ~ex_in & ~div_done;
    ex_ready_go = ~is_div | ex_in | div_done;
  end

  // The partial remainder never exceeds the divisor, so only the compare needs 33 bits.
  assign step_rem = {rem_q, quo_q[31]};
  assign step_ge  = step_rem >= {1'b0, dsor_q};
  assign step_sub = step_rem[31:0] - dsor_q;
  assign q_next   = {quo_q[30:0], step_ge};
  assign r_next   = step_ge ? step_sub : step_rem[31:0];
  assign abs1     = (div_signed && src1_q[31]) ? -src1_q : src1_q;
  assign abs2     = (div_signed && src2_q[31]) ? -src2_q : src2_q;

  always_comb begin
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsor_d  = dsor_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    res_d   = res_q;
    if (state_q == DIV_IDLE && div_start) begin
      cnt_d   = '0;
      quo_d   = abs1;
      rem_d   = '0;
      dsor_d  = abs2;
      qsign_d = div_signed & (src1_q[31] ^ src2_q[31]);
      rsign_d = div_signed & src1_q[31];
    end else if (state_q == DIV_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      quo_d = q_next;
      rem_d = r_next;
      if (cnt_q == LAST_STEP) begin
        if (div_is_mod) res_d = rsign_q ? -r_next : r_next;
        else            res_d = qsign_q ? -q_next : q_next;
      end
    end
  end

  assign mem_pc        = pc_q;
  assign mem_result    = (is_div && !ex_in) ? res_q : alu_q;
  assign mem_ld_size   = mem_rd_q ? mem_size_q : 3'b000;
  assign mem_ld_signed = mem_signed_q;
  assign mem_ctrl      = ctrl_q;

  assign is_mem  = mem_rd_q | mem_wr_q;
  assign addr_lo = alu_q[1:0];

  assign mem_ex_ADEM = is_mem & ((mem_size_q[1] & addr_lo[0]) | (mem_size_q[2] & (|addr_lo)));

  // Gating on the MEM handshake makes the request fire exactly once per instruction.
  assign data_sram_en = ex_valid_q & is_mem & ~mem_ex_ADEM & ~ex_in & ~later_ex & ~flush
                        & ex_ready_go & MEM_allow_in;
  assign data_sram_addr = {alu_q[31:2], 2'b00};

  always_comb begin
    data_sram_we = 4'b0000;
    if (ex_valid_q && mem_wr_q) begin
      if (mem_size_q[0])      data_sram_we = 4'b0001 << addr_lo;
      else if (mem_size_q[1]) data_sram_we = 4'b0011 << addr_lo;
      else if (mem_size_q[2]) data_sram_we = 4'b1111;
    end
  end

  always_comb begin
    if (mem_size_q[0])      data_sram_wdata = {4{st_data_q[7:0]}};
    else if (mem_size_q[1]) data_sram_wdata = {2{st_data_q[15:0]}};
    else                    data_sram_wdata = st_data_q;
  end

  assign fwd_dest    = (ex_valid_q && ctrl_q[CTRL_W-6]) ? ctrl_q[CTRL_W-1 -: 5] : 5'd0;
  assign fwd_result  = mem_result;
  assign fwd_is_load = ex_valid_q & (mem_rd_q | div_pending);

endmodule
